// File: rtl/digit_entry_loader_pkg.sv
// digit_entry_loader_pkg: debouncer state encodings and timing defaults shared by button consumers
package digit_entry_loader_pkg;
    localparam int DEBOUNCE_CYCLES_DEFAULT = 1000000;
    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        HELD         = 2'd2,
        RELEASE_WAIT = 2'd3
    } db_state_t;
endpackage

// File: rtl/digit_entry_loader_btn_debounce.sv
// btn_debounce: two-flop synchronizer plus debounce FSM giving one strobe per physical press
module btn_debounce
    import digit_entry_loader_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic btnIn,
    output logic pressStrobe
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
    logic [1:0] sync_q;
    db_state_t state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic strobe_q, strobe_d;
    logic in_s;
    assign in_s = sync_q[1];
    assign pressStrobe = strobe_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q   <= '0;
            state_q  <= IDLE;
            cnt_q    <= '0;
            strobe_q <= 1'b0;
        end else begin
            sync_q   <= {sync_q[0], btnIn};
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            strobe_q <= strobe_d;
        end
    end
    // Counter restarts from zero on every state change or interrupted wait, so it never wraps.
    always_comb begin
        state_d  = state_q;
        cnt_d    = '0;
        strobe_d = 1'b0;
        case (state_q)
            IDLE:         state_d = in_s ? PRESS_WAIT : IDLE;
            PRESS_WAIT:   if (!in_s) state_d = IDLE;
                          else if (cnt_q == LAST) begin
                              state_d  = HELD;
                              strobe_d = 1'b1;
                          end else cnt_d = cnt_q + 1'b1;
            HELD:         state_d = in_s ? HELD : RELEASE_WAIT;
            RELEASE_WAIT: if (in_s) state_d = HELD;
                          else if (cnt_q == LAST) state_d = IDLE;
                          else cnt_d = cnt_q + 1'b1;
            default:      state_d = IDLE;
        endcase
    end
endmodule

// File: rtl/digit_entry_loader.sv
// digit_entry_loader: shifts switch bytes into a display word on debounced load/clear presses
module digit_entry_loader
    import digit_entry_loader_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        btnLoad,
    input  logic        btnClear,
    input  logic [7:0]  dataIn,
    output logic [15:0] dispWord,
    output logic [1:0]  byteCount,
    output logic        loadPulse
);
    logic load_s, clear_s;
    logic [15:0] disp_q, disp_d;
    logic [1:0] cnt_q, cnt_d;
    logic pulse_q, pulse_d;
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_load (
        .clk(clk), .rst(rst), .btnIn(btnLoad), .pressStrobe(load_s)
    );
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clear (
        .clk(clk), .rst(rst), .btnIn(btnClear), .pressStrobe(clear_s)
    );
    assign dispWord  = disp_q;
    assign byteCount = cnt_q;
    assign loadPulse = pulse_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            disp_q  <= '0;
            cnt_q   <= '0;
            pulse_q <= 1'b0;
        end else begin
            disp_q  <= disp_d;
            cnt_q   <= cnt_d;
            pulse_q <= pulse_d;
        end
    end
    // Clear takes priority over a coincident load.
    always_comb begin
        disp_d  = disp_q;
        cnt_d   = cnt_q;
        pulse_d = 1'b0;
        if (clear_s) begin
            disp_d = '0;
            cnt_d  = '0;
        end else if (load_s) begin
            disp_d  = {disp_q[7:0], dataIn};
            cnt_d   = (cnt_q == 2'd2) ? 2'd2 : cnt_q + 2'd1;
            pulse_d = 1'b1;
        end
    end
endmodule

// File: tb/tb_digit_entry_loader.sv
// tb_digit_entry_loader: scoreboard bench, expected loads queued at press time and popped on loadPulse
module tb_digit_entry_loader;
    typedef struct {
        logic [15:0] w;
        logic [1:0]  c;
        int          due;
    } exp_t;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic btnLoad = 1'b0;
    logic btnClear = 1'b0;
    logic [7:0] dataIn = 8'h00;
    logic [15:0] dispWord;
    logic [1:0] byteCount;
    logic loadPulse;
    int cyc = 0;
    int checks = 0;
    int failures = 0;
    int npulse = 0;
    int nexp = 0;
    exp_t sb[$];
    logic [15:0] mw = '0;
    logic [1:0] mc = '0;
    digit_entry_loader #(.DEBOUNCE_CYCLES(4)) dut (
        .clk(clk), .rst(rst), .btnLoad(btnLoad), .btnClear(btnClear),
        .dataIn(dataIn), .dispWord(dispWord), .byteCount(byteCount), .loadPulse(loadPulse)
    );
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask
    always @(negedge clk) begin
        if (!rst && loadPulse) begin
            exp_t e;
            npulse++;
            if (sb.size() == 0) chk("unexpected_pulse", 32'd1, 32'd0);
            else begin
                e = sb.pop_front();
                chk("load_word", 32'(dispWord), 32'(e.w));
                chk("load_count", 32'(byteCount), 32'(e.c));
                chk("load_latency", 32'(cyc), 32'(e.due));
            end
        end
    end
    task automatic model_load(input logic [7:0] d);
        mw = {mw[7:0], d};
        mc = (mc == 2'd2) ? 2'd2 : mc + 2'd1;
        sb.push_back('{mw, mc, cyc + 8});
        nexp++;
    endtask
    task automatic press(input logic ld, input logic cl, input logic [7:0] d, input int hold);
        @(negedge clk);
        dataIn = d;
        btnLoad = ld;
        btnClear = cl;
        if (cl) begin
            mw = '0;
            mc = '0;
        end else if (ld) model_load(d);
        repeat (hold) @(negedge clk);
        btnLoad = 1'b0;
        btnClear = 1'b0;
        repeat (12) @(negedge clk);
    endtask
    task automatic chk_state(input string tag);
        chk({tag, "_word"}, 32'(dispWord), 32'(mw));
        chk({tag, "_count"}, 32'(byteCount), 32'(mc));
    endtask
    initial begin
        logic [0:4] bounce;
        bounce = 5'b10110;
        repeat (3) @(negedge clk);
        chk_state("reset");
        chk("reset_pulse", 32'(loadPulse), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        press(1'b1, 1'b0, 8'hA5, 20);
        chk_state("first_load");
        press(1'b0, 1'b1, 8'h00, 10);
        chk_state("clear");
        press(1'b1, 1'b0, 8'h12, 8);
        press(1'b1, 1'b0, 8'h34, 8);
        press(1'b1, 1'b0, 8'h56, 8);
        chk_state("saturate");
        dataIn = 8'h77;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            btnLoad = bounce[i];
        end
        press(1'b1, 1'b0, 8'h77, 10);
        chk_state("bounce");
        press(1'b0, 1'b1, 8'h00, 10);
        press(1'b1, 1'b0, 8'h12, 8);
        press(1'b1, 1'b0, 8'h34, 8);
        chk_state("pre_both");
        press(1'b1, 1'b1, 8'hFF, 10);
        chk_state("both_clear");
        press(1'b1, 1'b0, 8'hEE, 8);
        @(negedge clk);
        dataIn = 8'h9C;
        btnLoad = 1'b1;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        #1;
        mw = '0;
        mc = '0;
        chk_state("mid_reset");
        chk("mid_reset_pulse", 32'(loadPulse), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        model_load(8'h9C);
        repeat (12) @(negedge clk);
        btnLoad = 1'b0;
        repeat (12) @(negedge clk);
        chk_state("post_reset");
        @(negedge clk);
        dataIn = 8'h42;
        btnLoad = 1'b1;
        model_load(8'h42);
        repeat (100) @(negedge clk);
        btnLoad = 1'b0;
        repeat (2) @(negedge clk);
        btnLoad = 1'b1;
        repeat (20) @(negedge clk);
        btnLoad = 1'b0;
        repeat (12) @(negedge clk);
        chk_state("long_hold");
        chk("pending_loads", 32'(sb.size()), 32'd0);
        chk("pulse_total", 32'(npulse), 32'(nexp));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/digit_entry_loader.md
DIGIT_ENTRY_LOADER -- requirements
Module: digit_entry_loader

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 1000000, number of consecutive stable synchronized samples needed to accept a button level change (10 ms at 100 MHz).
REQ-002 clk  input  1  single system clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 btnLoad  input  1  raw, bouncing, asynchronous push button; a press SHALL append dataIn to the display word.
REQ-005 btnClear  input  1  raw, bouncing, asynchronous push button; a press SHALL clear the display word.
REQ-006 dataIn  input  8  switch byte, sampled on the clock edge that performs a load.
REQ-007 dispWord  output  16  registered word feeding the four-digit seven-segment display top.
REQ-008 byteCount  output  2  registered count of bytes loaded since the last clear; saturates at 2.
REQ-009 loadPulse  output  1  registered, one clock wide; high for the cycle after each accepted load.

Function
REQ-010 Each button SHALL pass through a two-flop synchronizer before any other logic.
REQ-011 Each synchronized button SHALL be debounced by an FSM with states IDLE, PRESS_WAIT, HELD and RELEASE_WAIT.
REQ-012 IDLE->PRESS_WAIT on a synchronized high; PRESS_WAIT->HELD after DEBOUNCE_CYCLES consecutive high samples; any low sample in PRESS_WAIT SHALL return to IDLE and clear the counter.
REQ-013 HELD->RELEASE_WAIT on a synchronized low; RELEASE_WAIT->IDLE after DEBOUNCE_CYCLES consecutive low samples; any high sample in RELEASE_WAIT SHALL return to HELD and clear the counter.
REQ-014 The debouncer SHALL emit a one-cycle press strobe on the PRESS_WAIT->HELD transition only, giving exactly one strobe per physical press regardless of hold time.
REQ-015 Strobe latency: if the raw button is high at edge N and stays high, the strobe SHALL be high in the cycle following edge N+2+DEBOUNCE_CYCLES.
REQ-016 On a load strobe: dispWord <= {dispWord[7:0], dataIn}; byteCount <= min(byteCount+1, 2); loadPulse <= 1 on the same edge.
REQ-017 Loads beyond byteCount=2 SHALL still shift, discarding the old upper byte; byteCount SHALL stay 2.
REQ-018 On a clear strobe: dispWord <= 0; byteCount <= 0; loadPulse <= 0.
REQ-019 If load and clear strobes occur in the same cycle, clear SHALL win and no load occurs.
REQ-020 With no strobe, dispWord and byteCount SHALL hold and loadPulse SHALL be 0.
REQ-021 The counter width SHALL be clog2(DEBOUNCE_CYCLES+1); the counter SHALL never wrap.

Reset
REQ-022 While rst is high: dispWord=16'h0000, byteCount=0, loadPulse=0, all debouncers in IDLE with counters 0, synchronizer flops 0.
REQ-023 A reset asserted mid-debounce SHALL abort it; after release, a still-held button SHALL go through a full PRESS_WAIT period before producing a strobe.
REQ-024 The first clock edge after rst deasserts SHALL produce no strobe or load.

Structure
REQ-025 The debouncer FSM state encodings and the default DEBOUNCE_CYCLES constant SHALL live in the shared display package/include so that other button consumers reuse them.
REQ-026 The synchronizer, FSM and counter SHALL form one sub-module, btn_debounce (ports clk, rst, btnIn, pressStrobe), instantiated twice.
REQ-027 The top level SHALL contain only the load/clear datapath registers and the two btn_debounce instances.

Verification (DEBOUNCE_CYCLES=4)
REQ-028 Reset, then dataIn=8'hA5, press btnLoad cleanly for 20 cycles -> dispWord=16'h00A5, byteCount=1, exactly one loadPulse, 7 cycles after first high sample.
REQ-029 Load 8'h12 then 8'h34 then 8'h56 -> dispWord 16'h0012, 16'h1234, 16'h3456 in turn; byteCount 1, 2, 2.
REQ-030 btnLoad bouncing 1,0,1,1,0 then stable high -> a single load, timed from the start of the stable run.
REQ-031 btnLoad and btnClear pressed on the same cycle with dispWord=16'h1234 -> dispWord=16'h0000, byteCount=0, no loadPulse.
REQ-032 Assert rst for 1 cycle during PRESS_WAIT with btnLoad held -> outputs 0 immediately; one load after a full 2+4 cycles post-reset.
REQ-033 Hold btnLoad for 100 cycles -> exactly one loadPulse; releasing for under 4 cycles and re-pressing -> no additional load.
